id_ex_ctrl_pipe: RTL and testbench
==================================

ID_EX_CTRL_PIPE -- requirements
Module: id_ex_ctrl_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 13, bit width of one control word (RegWrite, MemWrite, Jump, Branch, ALUSrcA, ALUSrcB[1:0], ResultSrc[1:0], ALUControl[3:0]).
REQ-002 SHALL provide parameter STAGES, default 3, number of chained register stages (E, M, W); legal range 1..8.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port in_valid  input  1  decode stage presents a live control word.
REQ-006 SHALL provide port in_data  input  WIDTH  control word from decode.
REQ-007 SHALL provide port stall  input  STAGES  per-stage hold request; bit k targets stage k.
REQ-008 SHALL provide port clear  input  STAGES  per-stage flush request; bit k squashes stage k.
REQ-009 SHALL provide port in_ready  output  1  stage 0 accepts in_data this cycle.
REQ-010 SHALL provide port out_valid  output  STAGES  valid bit of each stage.
REQ-011 SHALL provide port out_data  output  STAGES*WIDTH  flattened stage contents; stage k at bits [k*WIDTH +: WIDTH].

Function
REQ-012 SHALL compute hold[STAGES-1] = stall[STAGES-1] and hold[k] = stall[k] | hold[k+1] for k < STAGES-1 (hold propagates upstream, combinational).
REQ-013 SHALL drive in_ready = ~hold[0] combinationally.
REQ-014 SHALL give per-stage priority clear > hold > advance each cycle.
REQ-015 On clear[k], stage k SHALL load valid=0, data=0 regardless of hold[k].
REQ-016 On hold[k] without clear[k], stage k SHALL retain valid and data unchanged.
REQ-017 On advance, stage 0 SHALL load in_valid and in_data; stage k>0 SHALL load stage k-1's current valid and data.
REQ-018 When stage k advances while stage k-1 holds, stage k SHALL load a bubble (valid=0, data=0).
REQ-019 Any stage loading valid=0 SHALL load data=0, so an invalid stage never presents an asserted control bit.
REQ-020 Latency SHALL be one cycle per stage: an unstalled word presented at edge n appears at stage k after edge n+k.
REQ-021 clear[k] and stall[j] asserted together SHALL both take effect; a cleared stage still propagates hold upstream if stall[k]=1.

Reset
REQ-022 reset=1 SHALL immediately, asynchronously, set every out_valid bit to 0 and every out_data bit to 0, including mid-operation.
REQ-023 After reset deassertion, the first rising edge SHALL behave per REQ-014..019 with no extra dead cycle.

Configuration
REQ-024 Macro ID_EX_CTRL_PIPE_BUBBLE_CNT_EN SHALL, when defined, add output port bubble_cnt  output  16  count of cycles after which stage STAGES-1 holds valid=0.
REQ-025 With the macro defined, bubble_cnt SHALL reset to 0, increment by 1 on each rising edge at which the last stage loads or retains valid=0, and saturate at 16'hFFFF.
REQ-026 Without the macro, port bubble_cnt and its counter SHALL be absent; all other behaviour is identical.

Verification (WIDTH=13, STAGES=3)
REQ-027 Flow: in_valid=1, in_data=13'h1A5 for one cycle, no stall/clear -> out_valid=3'b001,3'b010,3'b100 on successive cycles; data 13'h1A5 at each stage.
REQ-028 Load-use stall: stall=3'b001 for one cycle with word A in stage 0 -> in_ready=0, stage 0 keeps A, stage 1 loads bubble (valid=0, data=0), A reaches stage 1 one cycle late.
REQ-029 Backpressure: stall=3'b100 for 2 cycles with stages full -> all three stages hold, in_ready=0; release -> pipeline resumes with no word lost or duplicated.
REQ-030 Branch flush: clear=3'b011 with stages full of 13'h1FFF -> next cycle out_valid[1:0]=0, out_data stages 0-1 = 0, stage 2 advanced normally.
REQ-031 Priority: stall=3'b010 and clear=3'b010 same cycle -> stage 1 becomes bubble, stage 0 holds, stage 2 loads bubble.
REQ-032 Reset mid-stream: assert reset between clock edges with valid words in flight -> all outputs 0 before next edge; with macro defined, bubble_cnt=0 and increments to 3 after 3 idle cycles following release.

Source files
------------

// File: rtl/id_ex_ctrl_pipe.sv
// Chained ID->EX->MEM->WB control-word pipeline with per-stage stall/flush and upstream hold propagation.
// Optional: define ID_EX_CTRL_PIPE_BUBBLE_CNT_EN to add a saturating 16-bit last-stage bubble counter.
module id_ex_ctrl_pipe #(
   parameter int WIDTH  = 13,
   parameter int STAGES = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   input  logic [WIDTH-1:0]          in_data,
   input  logic [STAGES-1:0]         stall,
   input  logic [STAGES-1:0]         clear,
   output logic                      in_ready,
   output logic [STAGES-1:0]         out_valid,
   output logic [STAGES*WIDTH-1:0]   out_data
`ifdef ID_EX_CTRL_PIPE_BUBBLE_CNT_EN
   ,
   output logic [15:0]               bubble_cnt
`endif
);

   logic [STAGES-1:0]       valid_q, valid_d;
   logic [STAGES*WIDTH-1:0] data_q, data_d;
   logic [STAGES-1:0]       hold;
   logic [STAGES-1:0]       up_valid;
   logic [STAGES-1:0]       up_hold;
   logic [STAGES*WIDTH-1:0] up_data;

   // A stage holds if it or any downstream stage stalls.
   always_comb begin
      hold = '0;
      for (int k = 0; k < STAGES; k++) begin
         hold[k] = |(stall >> k);
      end
   end

   // Upstream view of each stage: stage 0 sees the decode input, which never holds.
   always_comb begin
      up_valid = STAGES'({valid_q, in_valid});
      up_data  = (STAGES*WIDTH)'({data_q, in_data});
      up_hold  = STAGES'({hold, 1'b0});
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      for (int k = 0; k < STAGES; k++) begin
         if (clear[k]) begin
            valid_d[k]                = 1'b0;
            data_d[k*WIDTH +: WIDTH]  = '0;
         end else if (!hold[k]) begin
            valid_d[k]                = up_valid[k] & ~up_hold[k];
            data_d[k*WIDTH +: WIDTH]  = up_data[k*WIDTH +: WIDTH]
                                        & {WIDTH{up_valid[k] & ~up_hold[k]}};
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign in_ready  = ~hold[0];
   assign out_valid = valid_q;
   assign out_data  = data_q;

`ifdef ID_EX_CTRL_PIPE_BUBBLE_CNT_EN
   logic [15:0] bubble_cnt_q, bubble_cnt_d;

   // Counts edges after which the last stage is empty; sticks at all-ones.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (!valid_d[STAGES-1] && (bubble_cnt_q != 16'hFFFF)) begin
         bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_cnt_q <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Directed bench for id_ex_ctrl_pipe (WIDTH=13, STAGES=3) using a queue of hand-derived expected states.
module tb_id_ex_ctrl_pipe;

   localparam int WIDTH  = 13;
   localparam int STAGES = 3;

   logic                    clk;
   logic                    reset;
   logic                    in_valid;
   logic [WIDTH-1:0]        in_data;
   logic [STAGES-1:0]       stall;
   logic [STAGES-1:0]       clear;
   logic                    in_ready;
   logic [STAGES-1:0]       out_valid;
   logic [STAGES*WIDTH-1:0] out_data;
`ifdef ID_EX_CTRL_PIPE_BUBBLE_CNT_EN
   logic [15:0]             bubble_cnt;
`endif

   typedef struct {
      string                   tag;
      logic [STAGES-1:0]       valid;
      logic [STAGES*WIDTH-1:0] data;
      int                      bc;
   } exp_t;

   exp_t score_q[$];
   int   test_count = 0;
   int   fail_count = 0;

   id_ex_ctrl_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .stall     (stall),
      .clear     (clear),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data)
`ifdef ID_EX_CTRL_PIPE_BUBBLE_CNT_EN
      ,
      .bubble_cnt(bubble_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      test_count++;
      assert (act === exp) else begin
         fail_count++;
         $error("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic push_exp(input string tag, input logic [STAGES-1:0] ev,
                           input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                           input logic [WIDTH-1:0] e2, input int bc);
      exp_t e;
      e.tag   = tag;
      e.valid = ev;
      e.data  = {e2, e1, e0};
      e.bc    = bc;
      score_q.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      test_count++;
      if (score_q.size() == 0) begin
         fail_count++;
         $error("[TB] FAIL scoreboard: got empty queue, expected an entry");
      end else begin
         test_count--;
         e = score_q.pop_front();
         check({e.tag, "_valid"}, 64'(out_valid), 64'(e.valid));
         check({e.tag, "_data"},  64'(out_data),  64'(e.data));
`ifdef ID_EX_CTRL_PIPE_BUBBLE_CNT_EN
         if (e.bc >= 0) check({e.tag, "_bubble"}, 64'(bubble_cnt), 64'(e.bc));
`endif
      end
   endtask

   // Called one time unit after a rising edge; drives, checks in_ready, clocks, then checks stage state.
   task automatic applyStimulus(input string tag, input logic iv, input logic [WIDTH-1:0] id,
                                input logic [STAGES-1:0] st, input logic [STAGES-1:0] cl,
                                input logic exp_rdy, input logic [STAGES-1:0] ev,
                                input logic [WIDTH-1:0] e0, input logic [WIDTH-1:0] e1,
                                input logic [WIDTH-1:0] e2, input int bc = -1);
      push_exp(tag, ev, e0, e1, e2, bc);
      in_valid = iv;
      in_data  = id;
      stall    = st;
      clear    = cl;
      #1;
      check({tag, "_ready"}, 64'(in_ready), 64'(exp_rdy));
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      stall    = '0;
      clear    = '0;
      #2;
      push_exp("reset", 3'b000, 13'h0, 13'h0, 13'h0, 0);
      checkOutput();
      check("reset_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Single word flowing through all stages
      applyStimulus("flow0", 1'b1, 13'h1A5, 3'b000, 3'b000, 1'b1, 3'b001, 13'h1A5, 13'h0,   13'h0);
      applyStimulus("flow1", 1'b0, 13'h000, 3'b000, 3'b000, 1'b1, 3'b010, 13'h0,   13'h1A5, 13'h0);
      applyStimulus("flow2", 1'b0, 13'h000, 3'b000, 3'b000, 1'b1, 3'b100, 13'h0,   13'h0,   13'h1A5);
      applyStimulus("flow3", 1'b0, 13'h000, 3'b000, 3'b000, 1'b1, 3'b000, 13'h0,   13'h0,   13'h0);

      // Load-use stall on stage 0
      applyStimulus("lu_a",     1'b1, 13'h0A1, 3'b000, 3'b000, 1'b1, 3'b001, 13'h0A1, 13'h0,   13'h0);
      applyStimulus("lu_stall", 1'b1, 13'h0B2, 3'b001, 3'b000, 1'b0, 3'b001, 13'h0A1, 13'h0,   13'h0);
      applyStimulus("lu_rel",   1'b1, 13'h0B2, 3'b000, 3'b000, 1'b1, 3'b011, 13'h0B2, 13'h0A1, 13'h0);

      // Backpressure from the last stage
      applyStimulus("bp_fill", 1'b1, 13'h0C3, 3'b000, 3'b000, 1'b1, 3'b111, 13'h0C3, 13'h0B2, 13'h0A1);
      applyStimulus("bp_s1",   1'b1, 13'h0D4, 3'b100, 3'b000, 1'b0, 3'b111, 13'h0C3, 13'h0B2, 13'h0A1);
      applyStimulus("bp_s2",   1'b1, 13'h0D4, 3'b100, 3'b000, 1'b0, 3'b111, 13'h0C3, 13'h0B2, 13'h0A1);
      applyStimulus("bp_rel",  1'b1, 13'h0D4, 3'b000, 3'b000, 1'b1, 3'b111, 13'h0D4, 13'h0C3, 13'h0B2);
      applyStimulus("bp_dr0",  1'b0, 13'h000, 3'b000, 3'b000, 1'b1, 3'b110, 13'h0,   13'h0D4, 13'h0C3);
      applyStimulus("bp_dr1",  1'b0, 13'h000, 3'b000, 3'b000, 1'b1, 3'b100, 13'h0,   13'h0,   13'h0D4);
      applyStimulus("bp_dr2",  1'b0, 13'h000, 3'b000, 3'b000, 1'b1, 3'b000, 13'h0,   13'h0,   13'h0);

      // Branch flush of stages 0 and 1
      applyStimulus("fl_f0", 1'b1, 13'h1FFF, 3'b000, 3'b000, 1'b1, 3'b001, 13'h1FFF, 13'h0,    13'h0);
      applyStimulus("fl_f1", 1'b1, 13'h1FFF, 3'b000, 3'b000, 1'b1, 3'b011, 13'h1FFF, 13'h1FFF, 13'h0);
      applyStimulus("fl_f2", 1'b1, 13'h1FFF, 3'b000, 3'b000, 1'b1, 3'b111, 13'h1FFF, 13'h1FFF, 13'h1FFF);
      applyStimulus("flush", 1'b1, 13'h0E5,  3'b000, 3'b011, 1'b1, 3'b100, 13'h0,    13'h0,    13'h1FFF);

      // Clear beats stall on the same stage
      applyStimulus("p_f0",     1'b1, 13'h111, 3'b000, 3'b000, 1'b1, 3'b001, 13'h111, 13'h0,   13'h0);
      applyStimulus("p_f1",     1'b1, 13'h222, 3'b000, 3'b000, 1'b1, 3'b011, 13'h222, 13'h111, 13'h0);
      applyStimulus("p_f2",     1'b1, 13'h333, 3'b000, 3'b000, 1'b1, 3'b111, 13'h333, 13'h222, 13'h111);
      applyStimulus("prio",     1'b1, 13'h444, 3'b010, 3'b010, 1'b0, 3'b001, 13'h333, 13'h0,   13'h0);
      applyStimulus("prio_rel", 1'b1, 13'h444, 3'b000, 3'b000, 1'b1, 3'b011, 13'h444, 13'h333, 13'h0);

      // Stall and clear on different stages in the same cycle
      applyStimulus("cs",       1'b1, 13'h555, 3'b001, 3'b100, 1'b0, 3'b001, 13'h444, 13'h0,   13'h0);
      applyStimulus("r_f",      1'b1, 13'h666, 3'b000, 3'b000, 1'b1, 3'b011, 13'h666, 13'h444, 13'h0);

      // Asynchronous reset between edges with words in flight
      in_valid = 1'b0;
      in_data  = '0;
      reset    = 1'b1;
      #1;
      push_exp("mid_reset", 3'b000, 13'h0, 13'h0, 13'h0, 0);
      checkOutput();
      @(posedge clk);
      #1;
      reset = 1'b0;
      applyStimulus("idle1",    1'b0, 13'h000, 3'b000, 3'b000, 1'b1, 3'b000, 13'h0,   13'h0, 13'h0, 1);
      applyStimulus("idle2",    1'b0, 13'h000, 3'b000, 3'b000, 1'b1, 3'b000, 13'h0,   13'h0, 13'h0, 2);
      applyStimulus("idle3",    1'b0, 13'h000, 3'b000, 3'b000, 1'b1, 3'b000, 13'h0,   13'h0, 13'h0, 3);
      applyStimulus("post_rst", 1'b1, 13'h777, 3'b000, 3'b000, 1'b1, 3'b001, 13'h777, 13'h0, 13'h0, 4);

      if (score_q.size() != 0) begin
         test_count++;
         fail_count++;
         $error("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", score_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
